// File: rtl/keccak_pkg.sv
// Shared Keccak definitions used by the permutation arbiter and the
// sha3/shake front-ends.
//   KECCAK_STATE_W : width of a full Keccak-f[1600] state
//   KECCAK_LANE_W  : width of one of the 25 lanes
//   perm_fsm_e     : control states of the shared-permutation arbiter
package keccak_pkg;

    localparam int KECCAK_STATE_W = 1600;
    localparam int KECCAK_LANE_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } perm_fsm_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
//   req         : active requests, one bit per requester
//   ptr         : index that has the highest priority this round
//   grant       : one-hot winner (all zero when no request is active)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one request is active
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W:0] cand_s;

    // Walk the requesters from ptr upward, wrapping, and take the first active one.
    always_comb begin
        grant       = {NUM_REQ{1'b0}};
        grant_idx   = {PTR_W{1'b0}};
        grant_valid = 1'b0;
        cand_s      = {(PTR_W + 1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, ptr} + (PTR_W + 1)'(i);
            // The extra bit lets the sum exceed NUM_REQ-1 before folding back.
            if (cand_s >= NUM_REQ_W) begin
                cand_s = cand_s - NUM_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid && req[cand_s[PTR_W-1:0]]) begin
                grant_valid                = 1'b1;
                grant_idx                  = cand_s[PTR_W-1:0];
                grant[cand_s[PTR_W-1:0]]   = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/keccak_perm_arbiter.sv
// Shares one Keccak-f[1600] permutation core between NUM_REQ requesters.
// A round-robin winner is chosen in IDLE, its state is launched into the
// core, and the permuted state (or zero on watchdog timeout) is returned
// with a one-cycle ack pulse.
//   clk, rst        : clock, asynchronous active-low reset
//   req             : per-requester request, held until ack
//   req_state       : flattened input states, slice i = [1600*i +: 1600]
//   ack             : one-cycle completion pulse to the served requester
//   grant           : one-hot owner of the core, zero when idle
//   result_state    : permuted state, valid from the ack cycle on
//   err             : one-cycle pulse with ack when the core timed out
//   perm_enable     : one-cycle start pulse to the core
//   perm_state_in   : registered state presented to the core
//   perm_valid      : core completion strobe
//   perm_state_out  : core output state
module keccak_perm_arbiter
    import keccak_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*KECCAK_STATE_W-1:0] req_state,
    output logic [NUM_REQ-1:0]                ack,
    output logic [NUM_REQ-1:0]                grant,
    output logic [KECCAK_STATE_W-1:0]         result_state,
    output logic                              err,
    output logic                              perm_enable,
    output logic [KECCAK_STATE_W-1:0]         perm_state_in,
    input  logic                              perm_valid,
    input  logic [KECCAK_STATE_W-1:0]         perm_state_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    // The watchdog fires in the WAIT cycle that would make the count reach TIMEOUT_CYC.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    perm_fsm_e                  state_r;
    logic [PTR_W-1:0]           rr_ptr_r;
    logic [PTR_W-1:0]           g_idx_r;
    logic [WD_W-1:0]            wdog_r;

    logic [NUM_REQ-1:0]         arb_grant_s;
    logic [PTR_W-1:0]           arb_idx_s;
    logic                       arb_valid_s;
    logic [KECCAK_STATE_W-1:0]  sel_state_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req         (req),
        .ptr         (rr_ptr_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Pick the winner's state slice out of the flattened request bus.
    always_comb begin
        sel_state_s = {KECCAK_STATE_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_s == PTR_W'(i)) begin
                sel_state_s = req_state[i*KECCAK_STATE_W +: KECCAK_STATE_W];
            end else begin
                sel_state_s = sel_state_s;
            end
        end
    end

    // Control FSM: arbitration, core launch, watchdog and response pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= {PTR_W{1'b0}};
            g_idx_r       <= {PTR_W{1'b0}};
            wdog_r        <= {WD_W{1'b0}};
            grant         <= {NUM_REQ{1'b0}};
            ack           <= {NUM_REQ{1'b0}};
            err           <= 1'b0;
            perm_enable   <= 1'b0;
            perm_state_in <= {KECCAK_STATE_W{1'b0}};
            result_state  <= {KECCAK_STATE_W{1'b0}};
        end else begin
            // Pulse outputs are high for a single cycle only.
            perm_enable <= 1'b0;
            ack         <= {NUM_REQ{1'b0}};
            err         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant         <= arb_grant_s;
                        g_idx_r       <= arb_idx_s;
                        perm_state_in <= sel_state_s;
                        perm_enable   <= 1'b1;
                        state_r       <= ST_LAUNCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    wdog_r  <= {WD_W{1'b0}};
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A core result arriving on the expiry cycle still counts as success.
                    if (perm_valid) begin
                        result_state <= perm_state_out;
                        ack          <= grant;
                        grant        <= {NUM_REQ{1'b0}};
                        state_r      <= ST_RESP;
                    end else if (wdog_r == WD_LAST) begin
                        result_state <= {KECCAK_STATE_W{1'b0}};
                        ack          <= grant;
                        grant        <= {NUM_REQ{1'b0}};
                        err          <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    rr_ptr_r <= (g_idx_r == LAST_IDX) ? {PTR_W{1'b0}} : g_idx_r + PTR_W'(1);
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/keccak_perm_arbiter.md
KECCAK_PERM_ARBITER -- requirements
Module: keccak_perm_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one Keccak-f[1600] permutation core.
REQ-002 Parameter TIMEOUT_CYC, default 64, maximum cycles to wait for the core's perm_valid.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester permutation request; a requester holds it high until its ack.
REQ-006 req_state  input  NUM_REQ*1600  flattened per-requester input states; slice i = [1600*i +: 1600].
REQ-007 ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-008 grant  output  NUM_REQ  one-hot owner of the core; zero when idle.
REQ-009 result_state  output  1600  permuted state; valid in the ack cycle and held until the next capture.
REQ-010 err  output  1  one-cycle pulse, coincident with ack, when the core timed out.
REQ-011 perm_enable  output  1  one-cycle start pulse to the core.
REQ-012 perm_state_in  output  1600  registered state driven to the core.
REQ-013 perm_valid  input  1  core completion strobe.
REQ-014 perm_state_out  input  1600  core output state.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-016 IDLE with req != 0: select the winner g by round-robin, starting at pointer rr_ptr; register grant = onehot(g) and perm_state_in = req_state slice g; next state LAUNCH.
REQ-017 LAUNCH: perm_enable = 1 for exactly this cycle; clear the watchdog counter; next state WAIT.
REQ-018 WAIT: when perm_valid = 1, register result_state = perm_state_out; next state RESP.
REQ-019 WAIT: the watchdog increments each cycle without perm_valid; on reaching TIMEOUT_CYC, register result_state = 0, set the error flag, and go to RESP.
REQ-020 RESP: ack[g] = 1 and err = error flag, both for this one cycle; grant = 0; rr_ptr = (g+1) mod NUM_REQ; clear the error flag; next state IDLE.
REQ-021 Latency from req sampled in IDLE to ack is core latency + 3 cycles (IDLE, LAUNCH, RESP).
REQ-022 A req deasserted during LAUNCH or WAIT is ignored; the operation completes and ack is still issued.
REQ-023 A req still high in the IDLE cycle after RESP is a new request.
REQ-024 perm_valid outside WAIT is ignored.
REQ-025 perm_valid and watchdog expiry in the same cycle: perm_valid wins and err = 0.
REQ-026 rr_ptr wraps from NUM_REQ-1 to 0.
REQ-027 With all req high, grants cycle 0,1,...,NUM_REQ-1 in order, giving no starvation.
REQ-028 req_state is sampled only in the IDLE grant cycle; later changes do not affect the operation in flight.

Reset
REQ-029 rst low forces IDLE, grant = 0, ack = 0, err = 0, perm_enable = 0, perm_state_in = 0, result_state = 0, rr_ptr = 0, watchdog = 0, error flag = 0, immediately and independent of clk.
REQ-030 Reset during LAUNCH or WAIT abandons the operation with no ack, and any later perm_valid is ignored.
REQ-031 The first grant after reset release goes to the lowest-index active req.

Structure
REQ-032 Shared package keccak_pkg holds KECCAK_STATE_W = 1600 and the FSM state enum; the sha3/shake front-ends use it too.
REQ-033 Sub-module rr_arbiter (NUM_REQ req plus pointer in, one-hot grant plus index out, combinational) performs the winner selection.
REQ-034 Datapath registers (perm_state_in, result_state) have no reset dependency in the core interface beyond REQ-029.

Verification
REQ-035 Single requester: req = 4'b0001, state all zero -> one perm_enable pulse; ack[0] after core latency + 3; result lane 0 = 64'hF1258F7940E1DDE7; err = 0.
REQ-036 Contention: req = 4'b1111 held and re-asserted -> grant sequence 0001, 0010, 0100, 1000, 0001; exactly one ack per grant.
REQ-037 Wrap with gaps: rr_ptr = 3, req = 4'b0101 -> grant 0001, then 0100.
REQ-038 Timeout: core stub never asserts perm_valid -> ack[g] and err = 1 exactly 64 WAIT cycles after LAUNCH; result_state = 0; the next request is served normally.
REQ-039 Reset in WAIT: rst low for 1 cycle mid-permutation -> all outputs 0, no ack; a late perm_valid is ignored; a subsequent req = 4'b0010 is granted with grant = 0010.
REQ-040 Tie case: perm_valid in the same cycle as watchdog expiry -> ack with err = 0 and result_state = perm_state_out.
